uart_crc_fifo_bridge: RTL and testbench
=======================================

Name: uart_crc_fifo_bridge

Overview:
- UART-to-parallel bridge with three stages: UART receive front end (with CRC-8, error flags and echo), byte FIFO, and output stage.
- The front end receives serial bytes, checks frame and parity, accumulates a CRC-8 per message, echoes good bytes on tx and writes them into the FIFO.
- The output stage drains the FIFO and hands each byte to a downstream parallel link with a 4-phase req/ack handshake.
- Sits between the board RS-232 pins and the inter-board parallel link; also drives the 7-segment status display (out_data, crc).

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit (receive and transmit).
- DEPTH, 512, FIFO capacity in bytes (power of two, ≤512).
- IDLE_BITS, 10, idle-line bit times after the last byte that end a message.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; overrides everything.
- rx  in  1  UART input, idle high; 8 data bits LSB first, even parity, 1 stop.
- tx  out  1  UART echo output, same format; idle high.
- rx_enable  in  1  0: receiver ignores rx (an in-progress frame completes).
- out_enable  in  1  0: output stage issues no new FIFO reads.
- out_done  in  1  downstream ack for the output handshake.
- out_data  out  8  byte presented to the downstream link.
- out_start  out  1  handshake request.
- crc  out  8  CRC-8 of the current/last message.
- error  out  4  sticky flags: [0] parity, [1] framing, [2] overrun, [3] break.
- rx_finish  out  1  1-cycle pulse at end of message.
- out_finish  out  1  high while the output stage is idle and the FIFO is empty.
- fifo_count  out  10  bytes stored, 0..DEPTH.
- fifo_empty  out  1  fifo_count==0.
- fifo_full  out  1  fifo_count==DEPTH.

Behaviour:
- Reset: tx=1, out_data=0, out_start=0, crc=0, error=0, rx_finish=0, fifo_count=0, fifo_empty=1, fifo_full=0, out_finish=1. All FSMs go to IDLE and FIFO pointers are cleared.
- rx is double-flopped before use.
- RX FSM: IDLE → START → DATA(8) → PARITY → STOP → IDLE.
  - A 1→0 edge in IDLE starts a frame.
  - rx is sampled at count CLKS_PER_BIT/2-1 within each bit.
  - If the start sample is 1, the frame is a glitch: return to IDLE with no flags set.
- Stop sample 0 sets error[1].
  - If all 8 data bits and the parity bit are also 0, error[3] (break) is set instead and no byte is produced.
- Parity mismatch (ones in data+parity must be even) sets error[0]; the byte is dropped.
- Good byte, at the STOP sample cycle:
  - crc ← CRC-8 (poly 0x07, MSB-first, no reflection, no final XOR) of crc⊕byte.
  - If !fifo_full: one-cycle FIFO write and start of the echo.
  - If fifo_full: set error[2] and drop the byte; crc still updates.
- Echo TX: 11-bit frame, each bit CLKS_PER_BIT cycles. A good byte arriving while the transmitter is busy is not echoed (no queue).
- End of message: after at least one good byte, IDLE_BITS×CLKS_PER_BIT cycles with no new start bit → rx_finish pulses for 1 cycle.
- crc keeps its value until the first good byte of the next message; that byte restarts the CRC from init 0x00.
- error bits clear only on reset.
- FIFO:
  - Circular buffer, write and read pointers of log2(DEPTH)+1 bits.
  - Read data is registered: valid the cycle after rd.
  - A write when full or a read when empty is ignored.
  - Simultaneous read and write while non-empty: both occur and fifo_count is unchanged.
- OUT FSM: IDLE → READ → LATCH → REQ → WAITLOW → IDLE.
  - IDLE → READ when out_enable && !fifo_empty.
  - READ issues rd for 1 cycle.
  - LATCH loads out_data.
  - REQ asserts out_start and holds it until out_done=1.
  - Then out_start=0 and WAITLOW waits for out_done=0 before returning to IDLE.
  - out_data holds its value until the next LATCH.
- Throughput: at most one byte per 4 clk plus handshake time.
- reset mid-frame or mid-handshake: immediate return to reset values; a partial byte is discarded.

Test Plan:
- Reset → tx=1, fifo_empty=1, out_start=0, error=4'h0, crc=8'h00, out_finish=1.
- Send "123456789" (0x31..0x39, even parity), out_done tied to out_start with 2-cycle delay:
  - rx_finish pulses once, crc=8'hF4.
  - out_data sequence 0x31..0x39, one out_start per byte.
  - tx echoes the 9 bytes, error=0.
- Send 0x31 with the parity bit forced to 0 → error[0]=1, no FIFO write, fifo_count=0, crc unchanged, no echo.
- Stop bit forced low on 0x55 → error[1]=1. All-zero frame with stop low → error[3]=1 and error[1]=0.
- out_enable=0, send DEPTH+1 bytes:
  - fifo_count=DEPTH, fifo_full=1, error[2]=1.
  - Then out_enable=1 → DEPTH bytes emerge in order and fifo_empty=1 at the end.
- Hold out_done=0 during REQ → out_start stays 1 and out_data stable. Assert reset mid-REQ → out_start=0 on the next edge and fifo_count=0.

Source files
------------

// File: rtl/uart_crc_fifo_bridge_if.sv
// Downstream parallel link: byte plus 4-phase req/ack handshake and flow control.
// The bridge drives the link through the master modport.
interface uart_crc_fifo_bridge_if;
  logic [7:0] out_data;
  logic       out_start;
  logic       out_done;
  logic       out_enable;
  logic       out_finish;

  modport master (
    output out_data,
    output out_start,
    output out_finish,
    input  out_done,
    input  out_enable
  );

  modport slave (
    input  out_data,
    input  out_start,
    input  out_finish,
    output out_done,
    output out_enable
  );
endinterface

// File: rtl/uart_crc_fifo_bridge.sv
// UART receiver with parity/framing checks, CRC-8 per message and echo, feeding a byte FIFO
// that drains to a parallel link over a 4-phase req/ack handshake.
module uart_crc_fifo_bridge #(
  parameter int unsigned ClksPerBit = 16,
  parameter int unsigned Depth      = 512,
  parameter int unsigned IdleBits   = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  output logic                   tx,
  input  logic                   rx_enable,
  uart_crc_fifo_bridge_if.master out_link,
  output logic [7:0]             crc,
  output logic [3:0]             error,
  output logic                   rx_finish,
  output logic [9:0]             fifo_count,
  output logic                   fifo_empty,
  output logic                   fifo_full
);
  localparam int unsigned AddrW      = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned PtrW       = AddrW + 1;
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned IdleCycles = IdleBits * ClksPerBit;
  localparam int unsigned IdleW      = $clog2(IdleCycles + 1);
  localparam logic [CntW-1:0] SampleCnt = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] LastCnt   = CntW'(ClksPerBit - 1);

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
  typedef enum logic [2:0] {OutIdle, OutRead, OutLatch, OutReq, OutWaitLow} out_state_e;

  // CRC-8, poly 0x07, MSB first, applied to (crc ^ byte).
  function automatic logic [7:0] crc8_step(input logic [7:0] v);
    logic [7:0] c;
    c = v;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Receive front end
  rx_state_e       rx_state_q;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [2:0]      rx_bit_q;
  logic [7:0]      rx_data_q;
  logic            rx_par_q;
  logic [7:0]      crc_q;
  logic [3:0]      error_q;
  logic            msg_active_q;
  logic [IdleW-1:0] idle_cnt_q;
  logic            rx_finish_q;
  logic            fifo_wr_q;
  logic [7:0]      fifo_wdata_q;
  logic            tx_start_q;
  logic            tx_busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q   <= RxIdle;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_data_q    <= '0;
      rx_par_q     <= 1'b0;
      crc_q        <= '0;
      error_q      <= '0;
      msg_active_q <= 1'b0;
      idle_cnt_q   <= '0;
      rx_finish_q  <= 1'b0;
      fifo_wr_q    <= 1'b0;
      fifo_wdata_q <= '0;
      tx_start_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      fifo_wr_q   <= 1'b0;
      tx_start_q  <= 1'b0;
      rx_finish_q <= 1'b0;
      if (rx_state_q != RxIdle) begin
        rx_cnt_q <= (rx_cnt_q == LastCnt) ? '0 : rx_cnt_q + 1'b1;
      end
      unique case (rx_state_q)
        RxIdle: begin
          rx_cnt_q <= '0;
          if (rx_enable && rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RxStart;
            idle_cnt_q <= '0;
          end else if (msg_active_q) begin
            if (idle_cnt_q == IdleW'(IdleCycles - 1)) begin
              rx_finish_q  <= 1'b1;
              msg_active_q <= 1'b0;
              idle_cnt_q   <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end
        end
        RxStart: begin
          if (rx_cnt_q == SampleCnt && rx_sync_q) begin
            rx_state_q <= RxIdle;  // glitch, not a real start bit
          end else if (rx_cnt_q == LastCnt) begin
            rx_state_q <= RxData;
            rx_bit_q   <= '0;
          end
        end
        RxData: begin
          if (rx_cnt_q == SampleCnt) rx_data_q <= {rx_sync_q, rx_data_q[7:1]};
          if (rx_cnt_q == LastCnt) begin
            if (rx_bit_q == 3'd7) rx_state_q <= RxParity;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end
        end
        RxParity: begin
          if (rx_cnt_q == SampleCnt) rx_par_q <= rx_sync_q;
          if (rx_cnt_q == LastCnt)   rx_state_q <= RxStop;
        end
        RxStop: begin
          if (rx_cnt_q == SampleCnt) begin
            rx_state_q <= RxIdle;
            if (!rx_sync_q) begin
              if (rx_data_q == 8'h00 && !rx_par_q) error_q[3] <= 1'b1;
              else                                 error_q[1] <= 1'b1;
            end else if (^{rx_data_q, rx_par_q}) begin
              error_q[0] <= 1'b1;
            end else begin
              // First good byte of a new message restarts the CRC from zero.
              crc_q        <= crc8_step((msg_active_q ? crc_q : 8'h00) ^ rx_data_q);
              msg_active_q <= 1'b1;
              idle_cnt_q   <= '0;
              if (fifo_full) begin
                error_q[2] <= 1'b1;
              end else begin
                fifo_wr_q    <= 1'b1;
                fifo_wdata_q <= rx_data_q;
                tx_start_q   <= !tx_busy_q;
              end
            end
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  assign crc       = crc_q;
  assign error     = error_q;
  assign rx_finish = rx_finish_q;

  // Echo transmitter: start bit goes out on launch, then 10 shifted bits.
  logic            tx_q;
  logic [9:0]      tx_shift_q;
  logic [3:0]      tx_left_q;
  logic [CntW-1:0] tx_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_left_q  <= '0;
      tx_cnt_q   <= '0;
    end else if (tx_start_q) begin
      tx_q       <= 1'b0;
      tx_busy_q  <= 1'b1;
      tx_shift_q <= {1'b1, ^fifo_wdata_q, fifo_wdata_q};
      tx_left_q  <= 4'd10;
      tx_cnt_q   <= '0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == LastCnt) begin
        tx_cnt_q <= '0;
        if (tx_left_q == 4'd0) begin
          tx_busy_q <= 1'b0;
        end else begin
          tx_q       <= tx_shift_q[0];
          tx_shift_q <= {1'b1, tx_shift_q[9:1]};
          tx_left_q  <= tx_left_q - 4'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

  assign tx = tx_q;

  // Byte FIFO: extra pointer bit distinguishes full from empty.
  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, used;
  logic [7:0]      rd_data_q;
  logic            fifo_rd, wr_en, rd_en;

  assign used       = wr_ptr_q - rd_ptr_q;
  assign fifo_count = 10'(used);
  assign fifo_empty = (used == '0);
  assign fifo_full  = (used == PtrW'(Depth));
  assign wr_en      = fifo_wr_q && !fifo_full;
  assign rd_en      = fifo_rd && !fifo_empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AddrW-1:0]] <= fifo_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q[AddrW-1:0]];
      end
    end
  end

  // Output stage
  out_state_e out_state_q;
  logic [7:0] out_data_q;
  logic       out_start_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_state_q <= OutIdle;
      out_data_q  <= '0;
      out_start_q <= 1'b0;
    end else begin
      unique case (out_state_q)
        OutIdle:  if (out_link.out_enable && !fifo_empty) out_state_q <= OutRead;
        OutRead:  out_state_q <= OutLatch;
        OutLatch: begin
          out_data_q  <= rd_data_q;
          out_start_q <= 1'b1;
          out_state_q <= OutReq;
        end
        OutReq: begin
          if (out_link.out_done) begin
            out_start_q <= 1'b0;
            out_state_q <= OutWaitLow;
          end
        end
        OutWaitLow: if (!out_link.out_done) out_state_q <= OutIdle;
        default:    out_state_q <= OutIdle;
      endcase
    end
  end

  assign fifo_rd             = (out_state_q == OutRead);
  assign out_link.out_data   = out_data_q;
  assign out_link.out_start  = out_start_q;
  assign out_link.out_finish = (out_state_q == OutIdle) && fifo_empty;
endmodule

// File: tb/tb_uart_crc_fifo_bridge.sv
// Bench for uart_crc_fifo_bridge: vector table for frame errors plus hand-written sequences,
// with scoreboard queues for the parallel output and the serial echo.
module tb_uart_crc_fifo_bridge;
  localparam int unsigned Cpb      = 8;
  localparam int unsigned Depth    = 16;
  localparam int unsigned IdleBits = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       tx;
  logic       rx_enable;
  logic [7:0] crc;
  logic [3:0] error;
  logic       rx_finish;
  logic [9:0] fifo_count;
  logic       fifo_empty;
  logic       fifo_full;

  uart_crc_fifo_bridge_if bus ();

  uart_crc_fifo_bridge #(
    .ClksPerBit(Cpb),
    .Depth     (Depth),
    .IdleBits  (IdleBits)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .tx        (tx),
    .rx_enable (rx_enable),
    .out_link  (bus),
    .crc       (crc),
    .error     (error),
    .rx_finish (rx_finish),
    .fifo_count(fifo_count),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full)
  );

  always #5 clk = ~clk;

  // Downstream responder: ack follows request two cycles later.
  logic auto_ack = 1'b0;
  logic ack_d1 = 1'b0;
  logic ack_d2 = 1'b0;
  always @(posedge clk) begin
    ack_d1 <= bus.out_start;
    ack_d2 <= ack_d1;
  end
  assign bus.out_done = auto_ack & ack_d2;

  int errors = 0;
  int checks = 0;
  int out_pulses = 0;
  int echo_cnt = 0;
  int finish_cnt = 0;
  logic [7:0] out_q[$];
  logic [7:0] echo_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc_model(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    logic       fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  // Output monitor: pop expected byte on each new request; data must hold while requesting.
  logic       prev_start = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] exp_out;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (bus.out_start === 1'b1 && !prev_start) begin
        out_pulses++;
        if (out_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_data_unexpected: got %02h expected none", bus.out_data);
        end else begin
          exp_out = out_q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(exp_out));
        end
      end else if (bus.out_start === 1'b1 && prev_start && bus.out_data !== prev_data) begin
        check("out_data_stable", 32'(bus.out_data), 32'(prev_data));
      end
    end
    prev_start = (bus.out_start === 1'b1);
    prev_data  = bus.out_data;
  end

  always @(negedge clk) if (rx_finish === 1'b1) finish_cnt++;

  // Echo monitor: decode tx frames mid-bit and compare against expected echoes.
  initial begin : tx_mon
    logic [9:0] fr;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        repeat (Cpb / 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          repeat (Cpb) @(negedge clk);
          fr[i] = tx;
        end
        echo_cnt++;
        if (echo_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL echo_unexpected: got %03h expected none", fr);
        end else begin
          e = echo_q.pop_front();
          check("echo_frame", 32'(fr), 32'({1'b1, ^e, e}));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic flip_par, input logic stop_bit);
    logic [10:0] fr;
    fr = {stop_bit, (^d) ^ flip_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = fr[i];
      repeat (Cpb) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * Cpb) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_q.delete();
    echo_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (!(out_q.size() == 0 && fifo_empty && bus.out_finish) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_in_time"}, 32'(n < budget), 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       flip_par;
    logic       stop_bit;
    logic       do_reset;
    logic       good;
    logic [3:0] exp_err;
    logic [7:0] exp_crc;
    logic [9:0] exp_count;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int         e0;
    int         n;
    logic [7:0] m;
    logic [7:0] d;

    vecs[0] = '{8'h31, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 8'hF4, 10'd0};
    vecs[1] = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 8'h00, 10'd0};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 8'h00, 10'd0};
    vecs[3] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, crc_model(8'h00, 8'hA5), 10'd1};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, crc_model(8'h00, 8'hFF), 10'd2};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, crc_model(8'h00, 8'hFF), 10'd2};

    reset = 1'b1;
    rx = 1'b1;
    rx_enable = 1'b1;
    bus.out_enable = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_out_start", 32'(bus.out_start), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_crc", 32'(crc), 32'd0);
    check("rst_rx_finish", 32'(rx_finish), 32'd0);
    check("rst_out_finish", 32'(bus.out_finish), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // "123456789" through the whole path with the auto-acking downstream.
    bus.out_enable = 1'b1;
    auto_ack = 1'b1;
    finish_cnt = 0;
    out_pulses = 0;
    echo_cnt = 0;
    m = 8'h00;
    for (int i = 0; i < 9; i++) begin
      d = 8'h31 + 8'(i);
      m = crc_model(m, d);
      out_q.push_back(d);
      echo_q.push_back(d);
      send_byte(d, 1'b0, 1'b1);
    end
    repeat (16 * Cpb) @(negedge clk);
    check("msg_rx_finish_pulses", 32'(finish_cnt), 32'd1);
    check("msg_crc_check_value", 32'(crc), 32'hF4);
    check("msg_crc_model", 32'(crc), 32'(m));
    check("msg_error", 32'(error), 32'd0);
    wait_drain("msg", 400);
    check("msg_out_pulses", 32'(out_pulses), 32'd9);
    check("msg_echo_count", 32'(echo_cnt), 32'd9);

    // Frame error vectors, output stage held off so fifo_count reflects writes.
    bus.out_enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_reset) do_reset();
      e0 = echo_cnt;
      if (vecs[i].good) begin
        out_q.push_back(vecs[i].data);
        echo_q.push_back(vecs[i].data);
      end
      send_byte(vecs[i].data, vecs[i].flip_par, vecs[i].stop_bit);
      repeat (12 * Cpb) @(negedge clk);
      check($sformatf("vec%0d_error", i), 32'(error), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_crc", i), 32'(crc), 32'(vecs[i].exp_crc));
      check($sformatf("vec%0d_fifo_count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_echo", i), 32'(echo_cnt - e0), 32'(vecs[i].good));
    end

    // Receiver disabled: line activity is ignored.
    do_reset();
    rx_enable = 1'b0;
    e0 = echo_cnt;
    send_byte(8'h77, 1'b0, 1'b1);
    repeat (12 * Cpb) @(negedge clk);
    check("rxdis_fifo_count", 32'(fifo_count), 32'd0);
    check("rxdis_crc", 32'(crc), 32'd0);
    check("rxdis_echo", 32'(echo_cnt - e0), 32'd0);
    rx_enable = 1'b1;

    // Overflow: Depth+1 bytes with the output stage off.
    do_reset();
    m = 8'h00;
    for (int i = 0; i <= int'(Depth); i++) begin
      d = 8'(i * 37 + 11);
      m = crc_model(m, d);
      if (i < int'(Depth)) begin
        out_q.push_back(d);
        echo_q.push_back(d);
      end
      send_byte(d, 1'b0, 1'b1);
    end
    repeat (12 * Cpb) @(negedge clk);
    check("ovf_fifo_count", 32'(fifo_count), 32'(Depth));
    check("ovf_fifo_full", 32'(fifo_full), 32'd1);
    check("ovf_error", 32'(error), 32'b0100);
    check("ovf_crc", 32'(crc), 32'(m));
    bus.out_enable = 1'b1;
    wait_drain("ovf", int'(Depth) * 40 + 100);
    check("ovf_fifo_empty", 32'(fifo_empty), 32'd1);

    // Downstream stalls: request and data must hold; reset mid-request.
    do_reset();
    auto_ack = 1'b0;
    out_q.push_back(8'h5A);
    echo_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b0, 1'b1);
    n = 0;
    while (bus.out_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hold_req_seen", 32'(n < 200), 32'd1);
    repeat (20) @(negedge clk);
    check("hold_out_start", 32'(bus.out_start), 32'd1);
    check("hold_out_data", 32'(bus.out_data), 32'h5A);
    out_q.push_back(8'h3C);
    echo_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b0, 1'b1);
    repeat (12 * Cpb) @(negedge clk);
    check("hold_fifo_count", 32'(fifo_count), 32'd1);
    check("hold_still_req", 32'(bus.out_start), 32'd1);
    reset = 1'b1;
    out_q.delete();
    echo_q.delete();
    @(posedge clk);
    #1;
    check("midreq_rst_out_start", 32'(bus.out_start), 32'd0);
    check("midreq_rst_fifo_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    auto_ack = 1'b1;
    repeat (4) @(negedge clk);
    check("end_out_q_empty", 32'(out_q.size()), 32'd0);
    check("end_echo_q_empty", 32'(echo_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
